// File: rtl/xilinx_fifo_sync_reader.sv
// Read-side adapter for a standard-mode (non-FWFT) block-RAM FIFO: issues RDEN against
// skid-buffer credit, captures DO after the read latency and presents a valid/ready stream.
module xilinx_fifo_sync_reader #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DO_REG     = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_rderr,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  fifo_rden,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level,
    output logic                  rd_err
);
    localparam int unsigned RL        = 1 + DO_REG;
    localparam int unsigned BUF_DEPTH = RL + 1;
    localparam logic [1:0]  LAST      = 2'(BUF_DEPTH - 1);

    logic [RL-1:0]         infl_q, infl_d;
    logic [DATA_WIDTH-1:0] mem_q [4];
    logic [1:0]            wptr_q, rptr_q;
    logic [1:0]            level_q, level_d;
    logic                  rd_err_q;
    logic [1:0]            inflight;
    logic                  pop, cap, credit_ok;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign inflight = 2'($countones(infl_q));
    assign pop      = m_valid & m_ready;
    // Tail of the in-flight shift register marks the cycle FIFO_DO carries the word.
    assign cap      = infl_q[RL-1];

    // Compare as (level + inflight) < (depth + pop) so nothing can underflow.
    assign credit_ok = ({1'b0, level_q} + {1'b0, inflight}) < (3'(BUF_DEPTH) + {2'b00, pop});
    assign fifo_rden = rstn & en & ~fifo_empty & credit_ok;

    if (RL == 1) begin : g_rl1
        assign infl_d = fifo_rden;
    end else begin : g_rln
        assign infl_d = {infl_q[RL-2:0], fifo_rden};
    end

    assign level_d = level_q + {1'b0, cap} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            infl_q   <= '0;
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            level_q  <= 2'd0;
            rd_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            infl_q   <= infl_d;
            level_q  <= level_d;
            rd_err_q <= rd_err_q | fifo_rderr;
            if (cap) begin
                mem_q[wptr_q] <= fifo_do;
                wptr_q        <= wrap_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= wrap_inc(rptr_q);
            end
        end
    end

    assign m_data  = mem_q[rptr_q];
    assign m_valid = (level_q != 2'd0);
    assign level   = level_q;
    assign rd_err  = rd_err_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(cap && !pop && (level_q == 2'(BUF_DEPTH))))
        else $error("skid buffer overflow");

endmodule

// File: tb/tb_xilinx_fifo_sync_reader.sv
// Bench for xilinx_fifo_sync_reader: two instances (DO_REG=0 and DO_REG=1), each fed by a
// behavioural FIFO model, checked against a queue scoreboard and a credit count.
module tb_xilinx_fifo_sync_reader;
    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] en, mready, rden, mvalid, rd_err, empty, force_err, model_err, rderr;
    logic [3:0] fdo [2];
    logic [3:0] mdata [2];
    logic [1:0] level [2];
    logic [3:0] fmem [2][256];
    logic [7:0] wr [2];
    logic [7:0] rd [2];
    logic [3:0] st1 [2];
    logic [3:0] st2 [2];
    logic [3:0] exp0 [$];
    logic [3:0] exp1 [$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    assign empty[0] = (wr[0] == rd[0]);
    assign empty[1] = (wr[1] == rd[1]);
    assign rderr    = model_err | force_err;
    assign fdo[0]   = st1[0];
    assign fdo[1]   = st2[1];

    xilinx_fifo_sync_reader #(.DATA_WIDTH(4), .DO_REG(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .en(en[0]), .fifo_empty(empty[0]), .fifo_rderr(rderr[0]),
        .fifo_do(fdo[0]), .fifo_rden(rden[0]), .m_valid(mvalid[0]), .m_ready(mready[0]),
        .m_data(mdata[0]), .level(level[0]), .rd_err(rd_err[0])
    );

    xilinx_fifo_sync_reader #(.DATA_WIDTH(4), .DO_REG(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .en(en[1]), .fifo_empty(empty[1]), .fifo_rderr(rderr[1]),
        .fifo_do(fdo[1]), .fifo_rden(rden[1]), .m_valid(mvalid[1]), .m_ready(mready[1]),
        .m_data(mdata[1]), .level(level[1]), .rd_err(rd_err[1])
    );

    // Standard-mode FIFO: DO updates at the edge that samples RDEN, plus one stage if DO_REG.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                rd[i]        <= wr[i];
                model_err[i] <= 1'b0;
                st1[i]       <= 4'h0;
                st2[i]       <= 4'h0;
            end else begin
                model_err[i] <= rden[i] & empty[i];
                st2[i]       <= st1[i];
                if (rden[i] && !empty[i]) begin
                    st1[i] <= fmem[i][rd[i]];
                    rd[i]  <= rd[i] + 8'd1;
                end
            end
        end
    end

    task automatic push_word(input int i, input logic [3:0] w);
        fmem[i][wr[i]] = w;
        wr[i] = wr[i] + 8'd1;
        if (i == 0) exp0.push_back(w);
        else exp1.push_back(w);
    endtask

    task automatic take_exp(input int i, output logic [3:0] w, output bit ok);
        w  = 4'h0;
        ok = 1'b0;
        if (i == 0) begin
            if (exp0.size() > 0) begin w = exp0.pop_front(); ok = 1'b1; end
        end else begin
            if (exp1.size() > 0) begin w = exp1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; en = 2'b00; mready = 2'b00; force_err = 2'b00;
        wr[0] = 8'd0; wr[1] = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (rden[i] !== 1'b0) begin bad++; $display("FAIL reset_rden%0d: got %b want 0", i, rden[i]); end
            total++; if (mvalid[i] !== 1'b0) begin bad++; $display("FAIL reset_valid%0d: got %b want 0", i, mvalid[i]); end
            total++; if (level[i] !== 2'd0) begin bad++; $display("FAIL reset_level%0d: got %0d want 0", i, level[i]); end
            total++; if (mdata[i] !== 4'h0) begin bad++; $display("FAIL reset_data%0d: got %h want 0", i, mdata[i]); end
            total++; if (rd_err[i] !== 1'b0) begin bad++; $display("FAIL reset_rderr%0d: got %b want 0", i, rd_err[i]); end
        end
        rstn = 1'b1;
    endtask

    // Preloaded FIFO, consumer always ready: back-to-back RDEN and beats, latency RL+1.
    task automatic test_burst(input int i, input int n, input int lat, input bit rnd);
        int first_rden = -1, last_rden = -1, n_rden = 0;
        int first_valid = -1, last_valid = -1, n_valid = 0;
        logic [3:0] w, want;
        bit ok;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            w = rnd ? 4'($urandom) : 4'(k + 1);
            push_word(i, w);
        end
        en[i] = 1'b1; mready[i] = 1'b1;
        for (int c = 0; c < n + 12; c++) begin
            #1;
            if (rden[i]) begin
                if (first_rden < 0) first_rden = c;
                last_rden = c; n_rden++;
            end
            if (mvalid[i]) begin
                if (first_valid < 0) first_valid = c;
                last_valid = c; n_valid++;
                take_exp(i, want, ok);
                total++;
                if (!ok || mdata[i] !== want) begin
                    bad++; $display("FAIL burst%0d_data: got %h want %h (expected beat=%0d)", i, mdata[i], want, ok);
                end
            end
            @(negedge clk);
        end
        #1;
        total++; if (n_rden != n) begin bad++; $display("FAIL burst%0d_rden_count: got %0d want %0d", i, n_rden, n); end
        total++; if (last_rden - first_rden != n - 1) begin bad++; $display("FAIL burst%0d_rden_span: got %0d want %0d", i, last_rden - first_rden, n - 1); end
        total++; if (n_valid != n) begin bad++; $display("FAIL burst%0d_beat_count: got %0d want %0d", i, n_valid, n); end
        total++; if (last_valid - first_valid != n - 1) begin bad++; $display("FAIL burst%0d_beat_span: got %0d want %0d", i, last_valid - first_valid, n - 1); end
        total++; if (first_valid - first_rden != lat) begin bad++; $display("FAIL burst%0d_latency: got %0d want %0d", i, first_valid - first_rden, lat); end
        total++; if (rden[i] !== 1'b0) begin bad++; $display("FAIL burst%0d_rden_empty: got %b want 0", i, rden[i]); end
        en[i] = 1'b0; mready[i] = 1'b0;
    endtask

    task automatic test_stall;
        int n_rden = 0, delivered = 0, gaps = 0;
        logic [3:0] held, want;
        bit ok, started = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) push_word(0, 4'($urandom));
        en[0] = 1'b1; mready[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rden[0]) n_rden++;
            if (mvalid[0]) begin
                if (started) begin
                    total++;
                    if (mdata[0] !== held) begin bad++; $display("FAIL stall_hold: got %h want %h", mdata[0], held); end
                end
                started = 1'b1;
                held = mdata[0];
            end
            @(negedge clk);
        end
        #1;
        total++; if (n_rden != 2) begin bad++; $display("FAIL stall_rden_count: got %0d want 2", n_rden); end
        total++; if (level[0] !== 2'd2) begin bad++; $display("FAIL stall_level: got %0d want 2", level[0]); end
        total++; if (mdata[0] !== exp0[0]) begin bad++; $display("FAIL stall_head: got %h want %h", mdata[0], exp0[0]); end
        @(negedge clk);
        mready[0] = 1'b1;
        started = 1'b0;
        for (int c = 0; c < 30 && delivered < 6; c++) begin
            #1;
            if (mvalid[0]) begin
                started = 1'b1;
                take_exp(0, want, ok);
                total++;
                if (!ok || mdata[0] !== want) begin bad++; $display("FAIL stall_data: got %h want %h", mdata[0], want); end
                delivered++;
            end else if (started) begin
                gaps++;
            end
            @(negedge clk);
        end
        total++; if (delivered != 6) begin bad++; $display("FAIL stall_delivered: got %0d want 6", delivered); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stall_gaps: got %0d want 0", gaps); end
        en[0] = 1'b0; mready[0] = 1'b0;
    endtask

    // Random trickle-in, random ready and enable on both instances at once.
    task automatic test_random;
        int pushed [2], delivered [2], outst [2], depth [2];
        int p;
        logic [3:0] want;
        bit ok;
        pushed = '{0, 0}; delivered = '{0, 0}; outst = '{0, 0}; depth = '{2, 3};
        for (int c = 0; c < 6000 && (delivered[0] < 200 || delivered[1] < 200); c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pushed[i] < 200 && $urandom_range(1, 0) == 1) begin
                    push_word(i, 4'($urandom));
                    pushed[i]++;
                end
                en[i]     = ($urandom_range(3, 0) != 0);
                mready[i] = ($urandom_range(1, 0) == 1);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                p = (mvalid[i] && mready[i]) ? 1 : 0;
                if (rden[i]) begin
                    total++;
                    if (empty[i] || !en[i]) begin bad++; $display("FAIL rand%0d_rden_gate: empty=%b en=%b want rden 0", i, empty[i], en[i]); end
                    total++;
                    if (outst[i] - p >= depth[i]) begin bad++; $display("FAIL rand%0d_credit: outstanding=%0d pop=%0d want <%0d", i, outst[i], p, depth[i]); end
                end
                if (p == 1) begin
                    take_exp(i, want, ok);
                    total++;
                    if (!ok || mdata[i] !== want) begin bad++; $display("FAIL rand%0d_data: got %h want %h", i, mdata[i], want); end
                    delivered[i]++;
                end
                outst[i] = outst[i] + (rden[i] ? 1 : 0) - p;
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (delivered[i] != 200) begin bad++; $display("FAIL rand%0d_delivered: got %0d want 200", i, delivered[i]); end
            total++; if (rd_err[i] !== 1'b0) begin bad++; $display("FAIL rand%0d_rderr: got %b want 0", i, rd_err[i]); end
        end
        en = 2'b00; mready = 2'b00;
    endtask

    task automatic test_reset_midstream;
        int n_rden = 0, delivered = 0;
        logic [3:0] want;
        bit ok;
        @(negedge clk);
        for (int k = 0; k < 6; k++) push_word(1, 4'($urandom));
        en[1] = 1'b1; mready[1] = 1'b0;
        for (int c = 0; c < 10 && n_rden < 2; c++) begin
            #1;
            if (rden[1]) n_rden++;
            @(negedge clk);
        end
        total++; if (n_rden != 2) begin bad++; $display("FAIL rstmid_inflight: got %0d want 2", n_rden); end
        rstn = 1'b0;
        #1;
        total++; if (rden !== 2'b00) begin bad++; $display("FAIL rstmid_rden_gate: got %b want 00", rden); end
        @(negedge clk);
        rstn = 1'b1;
        exp1.delete();
        #1;
        total++; if (mvalid[1] !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", mvalid[1]); end
        total++; if (level[1] !== 2'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", level[1]); end
        total++; if (rden[1] !== 1'b0) begin bad++; $display("FAIL rstmid_rden: got %b want 0", rden[1]); end
        @(negedge clk);
        push_word(1, 4'hA); push_word(1, 4'hB); push_word(1, 4'hC);
        mready[1] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (mvalid[1]) begin
                take_exp(1, want, ok);
                total++;
                if (!ok || mdata[1] !== want) begin bad++; $display("FAIL rstmid_data: got %h want %h", mdata[1], want); end
                delivered++;
            end
            @(negedge clk);
        end
        total++; if (delivered != 3) begin bad++; $display("FAIL rstmid_delivered: got %0d want 3", delivered); end
        en[1] = 1'b0; mready[1] = 1'b0;
    endtask

    task automatic test_rderr;
        @(negedge clk);
        force_err[0] = 1'b1;
        #1;
        total++; if (rd_err[0] !== 1'b0) begin bad++; $display("FAIL rderr_early: got %b want 0", rd_err[0]); end
        @(negedge clk);
        force_err[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (rd_err[0] !== 1'b1) begin bad++; $display("FAIL rderr_sticky: got %b want 1", rd_err[0]); end
            @(negedge clk);
        end
        #1;
        total++; if (rd_err[1] !== 1'b0) begin bad++; $display("FAIL rderr_other: got %b want 0", rd_err[1]); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        total++; if (rd_err[0] !== 1'b0) begin bad++; $display("FAIL rderr_clear: got %b want 0", rd_err[0]); end
    endtask

    initial begin
        test_reset();
        test_burst(0, 4, 2, 1'b0);
        test_burst(1, 8, 3, 1'b1);
        test_stall();
        test_random();
        test_reset_midstream();
        test_rderr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
